// File: rtl/cpu_pad_sequencer_if.sv
// rtl/cpu_pad_sequencer_if.sv - program-load and result channels of the CPU pad sequencer
interface cpu_pad_sequencer_if #(
    parameter int AW = 4
);
    logic          load_valid;
    logic [19:0]   load_data;
    logic          load_ready;
    logic          res_valid;
    logic [10:0]   res_data;
    logic [AW-1:0] res_index;
    logic          res_ready;

    modport master (
        input  load_valid, load_data, res_ready,
        output load_ready, res_valid, res_data, res_index
    );

    modport slave (
        output load_valid, load_data, res_ready,
        input  load_ready, res_valid, res_data, res_index
    );
endinterface

// File: rtl/cpu_pad_sequencer.sv
// rtl/cpu_pad_sequencer.sv - replays stored 20-bit words onto CPU pads and captures the 11-bit response (SEQ_COMPARE_EN adds expected-value checking)
module cpu_pad_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LAT   = 2
) (
    input  logic        pad_clk,
    input  logic        pad_rst,
    input  logic        prog_clr,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] pad_data_in,
    output logic [3:0]  bidir_inputs_from_pad,
    input  logic [10:0] bidir_output_data,
`ifdef SEQ_COMPARE_EN
    input  logic [10:0] load_expect,
    output logic        res_mismatch,
    output logic        fail_sticky,
`endif
    cpu_pad_sequencer_if.master bus
);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, RESULT, DONE} state_t;

    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [3:0]  WLOAD = 4'(LAT - 1);

    state_t        state, state_nxt;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [3:0]    wcnt, wcnt_nxt;
    logic          capture;
    logic [19:0]   pad_q;
    logic [10:0]   res_q;
    logic [19:0]   mem [DEPTH];

    logic idle, load_go, start_go, last_word, drive_nxt;

    assign idle      = (state == IDLE);
    assign load_go   = idle && !prog_clr && bus.load_valid && bus.load_ready;
    assign start_go  = idle && !prog_clr && start && (count != '0);
    assign last_word = ({1'b0, rd_ptr} == (count - 1'b1));
    assign drive_nxt = (state_nxt == DRIVE) || (state_nxt == WAIT) || (state_nxt == RESULT);

    assign busy                  = !idle;
    assign done                  = (state == DONE);
    assign bus.load_ready        = idle && (count < FULL);
    assign bus.res_valid         = (state == RESULT);
    assign bus.res_data          = res_q;
    assign bus.res_index         = rd_ptr;
    assign pad_data_in           = pad_q[15:0];
    assign bidir_inputs_from_pad = pad_q[19:16];

    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        wcnt_nxt   = wcnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start_go) begin
                    state_nxt  = DRIVE;
                    rd_ptr_nxt = '0;
                end
            end
            DRIVE: begin
                wcnt_nxt = WLOAD;
                if (LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // The counter reaching zero on this edge is the LAT-th edge after the word appeared.
                if (wcnt <= 4'd1) begin
                    wcnt_nxt  = '0;
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    if (last_word) begin
                        state_nxt = DONE;
                    end else begin
                        rd_ptr_nxt = rd_ptr + AW'(1);
                        state_nxt  = DRIVE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pad_clk) begin
        if (pad_rst) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wcnt   <= '0;
            pad_q  <= '0;
            res_q  <= '0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
            wcnt   <= wcnt_nxt;
            pad_q  <= drive_nxt ? mem[rd_ptr_nxt] : 20'h0;
            if (capture) begin
                res_q <= bidir_output_data;
            end
            if (idle && prog_clr) begin
                count <= '0;
            end else if (load_go) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge pad_clk) begin
        if (load_go) begin
            mem[count[AW-1:0]] <= bus.load_data;
        end
    end

`ifdef SEQ_COMPARE_EN
    logic [10:0] exp_mem [DEPTH];

    assign res_mismatch = bus.res_valid && (res_q != exp_mem[rd_ptr]);

    always_ff @(posedge pad_clk) begin
        if (load_go) begin
            exp_mem[count[AW-1:0]] <= load_expect;
        end
    end

    always_ff @(posedge pad_clk) begin
        if (pad_rst || start_go) begin
            fail_sticky <= 1'b0;
        end else if (res_mismatch && bus.res_ready) begin
            fail_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_pad_sequencer.sv
// tb/tb_cpu_pad_sequencer.sv - directed self-checking bench for cpu_pad_sequencer with a pad loopback model
module tb_cpu_pad_sequencer;

    logic        pad_clk;
    logic        pad_rst;
    logic        prog_clr;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] pad_data_in;
    logic [3:0]  bidir_inputs_from_pad;
    logic [10:0] bidir_output_data;
    logic [10:0] load_expect;
    logic        corrupt;
`ifdef SEQ_COMPARE_EN
    logic        res_mismatch;
    logic        fail_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    cpu_pad_sequencer_if #(.AW(4)) bus ();

    cpu_pad_sequencer #(.DEPTH(16), .AW(4), .LAT(2)) dut (
        .pad_clk               (pad_clk),
        .pad_rst               (pad_rst),
        .prog_clr              (prog_clr),
        .start                 (start),
        .busy                  (busy),
        .done                  (done),
        .pad_data_in           (pad_data_in),
        .bidir_inputs_from_pad (bidir_inputs_from_pad),
        .bidir_output_data     (bidir_output_data),
`ifdef SEQ_COMPARE_EN
        .load_expect           (load_expect),
        .res_mismatch          (res_mismatch),
        .fail_sticky           (fail_sticky),
`endif
        .bus                   (bus)
    );

    // CPU loopback: {bidir[2:0], data[7:0]}, optionally with bit 10 flipped
    assign bidir_output_data = {bidir_inputs_from_pad[2:0], pad_data_in[7:0]} ^ (corrupt ? 11'h400 : 11'h000);

    initial pad_clk = 1'b0;
    always #5 pad_clk = ~pad_clk;

    always @(posedge pad_clk) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pad_clk);
        #1;
    endtask

    task automatic load_word(input logic [19:0] w, input logic [10:0] e);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        load_expect    = e;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_res;
        int k;
        k = 0;
        while (!bus.res_valid && k < 20) begin
            tick();
            k++;
        end
        if (!bus.res_valid) check_eq("res_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_d;
        pad_rst = 1'b1; prog_clr = 1'b0; start = 1'b0; corrupt = 1'b0;
        load_expect = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.res_ready = 1'b0;
        tick(); tick();
        pad_rst = 1'b0;

        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_load_ready", bus.load_ready, 1);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_res_data", bus.res_data, 0);
        check_eq("rst_res_index", bus.res_index, 0);
        check_eq("rst_pads", {bidir_inputs_from_pad, pad_data_in}, 0);

        load_word(20'h1_0012, 11'h0);
        load_word(20'h2_0034, 11'h0);
        load_word(20'hF_FFFF, 11'h0);

        do_start();
        check_eq("w0_drive_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h1_0012);
        check_eq("w0_busy", busy, 1);
        check_eq("w0_load_blocked", bus.load_ready, 0);
        check_eq("w0_drive_valid", bus.res_valid, 0);
        tick();
        check_eq("w0_wait_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h1_0012);
        check_eq("w0_wait_valid", bus.res_valid, 0);
        tick();
        check_eq("w0_res_valid", bus.res_valid, 1);
        check_eq("w0_res_data", bus.res_data, 11'h112);
        check_eq("w0_res_index", bus.res_index, 0);
        check_eq("w0_res_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h1_0012);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_eq("w1_drive_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h2_0034);
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            check_eq("w1_hold_valid", bus.res_valid, 1);
            check_eq("w1_hold_index", bus.res_index, 1);
            check_eq("w1_hold_data", bus.res_data, 11'h234);
            check_eq("w1_hold_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h2_0034);
            tick();
        end
        check_eq("w1_hold6_index", bus.res_index, 1);
        bus.res_ready = 1'b1;
        tick();
        check_eq("w2_drive_pads", {bidir_inputs_from_pad, pad_data_in}, 20'hF_FFFF);
        check_eq("w2_drive_valid", bus.res_valid, 0);
        tick(); tick();
        check_eq("w2_res_valid", bus.res_valid, 1);
        check_eq("w2_res_data", bus.res_data, 11'h7FF);
        check_eq("w2_res_index", bus.res_index, 2);
        tick();
        check_eq("done_pulse", done, 1);
        check_eq("done_pads", {bidir_inputs_from_pad, pad_data_in}, 0);
        check_eq("done_busy", busy, 1);
        tick();
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("done_count1", done_cnt, 1);

        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            check_eq("fill_load_ready", bus.load_ready, (i < 16) ? 1 : 0);
            load_word({4'(i), 8'h00, 8'(i * 17 + 1)}, 11'h0);
        end
        check_eq("full_load_ready", bus.load_ready, 0);
        do_start();
        for (int i = 0; i < 16; i++) begin
            wait_res();
            exp_d = {3'(i), 8'(i * 17 + 1)};
            check_eq("full_res_index", bus.res_index, i);
            check_eq("full_res_data", bus.res_data, exp_d);
            tick();
        end
        check_eq("full_done", done, 1);
        tick();
        check_eq("full_idle", busy, 0);
        check_eq("done_count2", done_cnt, 2);

        prog_clr = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = 20'h5_5555;
        tick();
        prog_clr = 1'b0;
        bus.load_valid = 1'b0;
        check_eq("clr_load_ready", bus.load_ready, 1);
        do_start();
        check_eq("empty_start_busy", busy, 0);
        tick();
        check_eq("empty_start_busy2", busy, 0);
        check_eq("empty_start_done", done_cnt, 2);

        load_word(20'h3_0056, 11'h0);
        load_word(20'h0_0078, 11'h0);
        do_start();
        tick();
        check_eq("midwait_busy", busy, 1);
        check_eq("midwait_pads", {bidir_inputs_from_pad, pad_data_in}, 20'h3_0056);
        pad_rst = 1'b1;
        tick();
        pad_rst = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_pads", {bidir_inputs_from_pad, pad_data_in}, 0);
        check_eq("midrst_res_valid", bus.res_valid, 0);
        check_eq("midrst_load_ready", bus.load_ready, 1);
        do_start();
        check_eq("midrst_count0", busy, 0);

`ifdef SEQ_COMPARE_EN
        load_word(20'h0_0012, 11'h012);
        load_word(20'h0_0034, 11'h034);
        corrupt = 1'b1;
        do_start();
        check_eq("cmp_sticky_clr", fail_sticky, 0);
        wait_res();
        check_eq("cmp_res_data", bus.res_data, 11'h412);
        check_eq("cmp_mismatch", res_mismatch, 1);
        tick();
        corrupt = 1'b0;
        check_eq("cmp_sticky_set", fail_sticky, 1);
        wait_res();
        check_eq("cmp_match", res_mismatch, 0);
        tick(); tick();
        check_eq("cmp_sticky_hold", fail_sticky, 1);
        do_start();
        check_eq("cmp_sticky_start", fail_sticky, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
